// File: rtl/apb_rr_master_arbiter.sv
// Two-requester round-robin APB master: grants one request at a time, runs SETUP/ACCESS,
// and returns read data / error to the granted requester, aborting ACCESS after TIMEOUT cycles.
module apb_rr_master_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_req_valid,
  input  logic [1:0]              i_req_write,
  input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
  output logic [1:0]              o_req_ack,
  output logic [1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic                    o_PSEL,
  output logic                    o_PENABLE,
  output logic                    o_PWRITE,
  output logic [ADDR_WIDTH-1:0]   o_PADDR,
  output logic [DATA_WIDTH-1:0]   o_PWDATA,
  input  logic                    i_PREADY,
  input  logic [DATA_WIDTH-1:0]   i_PRDATA,
  input  logic                    i_PSLVERR,
  output logic [1:0]              o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Request side: valid/write/addr/wdata are held by the requester until o_req_ack pulses;
  // requests are only sampled in IDLE, and a valid still high afterwards is a new request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_q, grant_d;
  logic                    pick;
  logic [1:0]              ack_d, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic                    err_d;
  logic                    psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_d;

  assign o_dbg_state = state_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      o_req_ack    <= '0;
      o_rsp_valid  <= '0;
      o_rsp_rdata  <= '0;
      o_rsp_err    <= 1'b0;
      o_PSEL       <= 1'b0;
      o_PENABLE    <= 1'b0;
      o_PWRITE     <= 1'b0;
      o_PADDR      <= '0;
      o_PWDATA     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      o_req_ack    <= ack_d;
      o_rsp_valid  <= rsp_valid_d;
      o_rsp_rdata  <= rdata_d;
      o_rsp_err    <= err_d;
      o_PSEL       <= psel_d;
      o_PENABLE    <= penable_d;
      o_PWRITE     <= pwrite_d;
      o_PADDR      <= paddr_d;
      o_PWDATA     <= pwdata_d;
    end
  end

  // On contention the requester that did not win last time goes first.
  assign pick = (i_req_valid == 2'b11) ? ~last_grant_q : i_req_valid[1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ack_d        = '0;
    rsp_valid_d  = '0;
    rdata_d      = '0;
    err_d        = 1'b0;
    psel_d       = o_PSEL;
    penable_d    = o_PENABLE;
    pwrite_d     = o_PWRITE;
    paddr_d      = o_PADDR;
    pwdata_d     = o_PWDATA;
    case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          state_d      = SETUP;
          grant_d      = pick;
          last_grant_d = pick;
          ack_d        = pick ? 2'b10 : 2'b01;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          pwrite_d     = pick ? i_req_write[1] : i_req_write[0];
          paddr_d      = pick ? i_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_req_addr[ADDR_WIDTH-1:0];
          pwdata_d     = pick ? i_req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_wdata[DATA_WIDTH-1:0];
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (i_PREADY) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          rdata_d     = o_PWRITE ? '0 : i_PRDATA;
          err_d       = i_PSLVERR;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Slave never answered: release the bus and report an error.
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Bench for apb_rr_master_arbiter: APB memory slave with programmable wait/error,
// per-requester request queues and a transaction-level reference model.
module tb_apb_rr_master_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [1:0]      req_valid = '0;
  logic [1:0]      req_write = '0;
  logic [2*AW-1:0] req_addr  = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      o_req_ack, o_rsp_valid;
  logic [DW-1:0]   o_rsp_rdata;
  logic            o_rsp_err;
  logic            o_PSEL, o_PENABLE, o_PWRITE;
  logic [AW-1:0]   o_PADDR;
  logic [DW-1:0]   o_PWDATA;
  logic            i_PREADY = 1'b0;
  logic [DW-1:0]   i_PRDATA = '0;
  logic            i_PSLVERR = 1'b0;
  logic [1:0]      o_dbg_state;

  apb_rr_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_ack(o_req_ack), .o_rsp_valid(o_rsp_valid),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE), .o_PWRITE(o_PWRITE),
    .o_PADDR(o_PADDR), .o_PWDATA(o_PWDATA),
    .i_PREADY(i_PREADY), .i_PRDATA(i_PRDATA), .i_PSLVERR(i_PSLVERR),
    .o_dbg_state(o_dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- APB slave (environment) ----------------
  int slave_wait = 0;   // ACCESS cycles before PREADY; negative = never ready
  bit slave_err  = 1'b0;
  int acc_idx    = 0;
  logic [DW-1:0] mem [0:127];

  always @(negedge clk) begin
    if (o_PSEL && o_PENABLE) begin
      i_PREADY  = (slave_wait >= 0) && (acc_idx >= slave_wait);
      i_PSLVERR = i_PREADY && slave_err;
      i_PRDATA  = o_PWRITE ? $urandom : mem[o_PADDR];
      acc_idx++;
    end else begin
      i_PREADY  = 1'b0;
      i_PSLVERR = 1'b0;
      i_PRDATA  = $urandom;
      acc_idx   = 0;
    end
  end

  always @(posedge clk) begin
    if (o_PSEL && o_PENABLE && i_PREADY && o_PWRITE && !i_PSLVERR)
      mem[o_PADDR] <= o_PWDATA;
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] exp_mem [0:127];
  logic [39:0]   q0[$];       // {write, addr[6:0], wdata[31:0]}
  logic [39:0]   q1[$];
  logic [41:0]   exp_q[$];    // {requester, err, rdata[31:0], access_cycles[7:0]}
  bit            ack_log[$];
  int            ack_cyc[$];
  bit            model_last = 1'b1;
  logic [39:0]   cur = '0;
  int            acc_seen = 0;
  bit            rand_gap = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic present();
    logic [39:0] it;
    if (!req_valid[0] && q0.size() > 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
      it = q0[0];
      req_valid[0] = 1'b1;
      req_write[0] = it[39];
      req_addr[AW-1:0]  = it[38:32];
      req_wdata[DW-1:0] = it[31:0];
    end
    if (!req_valid[1] && q1.size() > 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
      it = q1[0];
      req_valid[1] = 1'b1;
      req_write[1] = it[39];
      req_addr[2*AW-1:AW]  = it[38:32];
      req_wdata[2*DW-1:DW] = it[31:0];
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    acc_seen = 0;
    exp_q.delete();
  endtask

  // Plays queued requests, predicts grants by round-robin rule and responses from exp_mem.
  task automatic run_traffic(input int max_cycles);
    int          cyc;
    bit          pred;
    bit          is_to;
    logic [1:0]  exp_ack;
    logic [41:0] e;
    logic [41:0] got;
    logic [DW-1:0] e_rd;
    cyc = 0;
    present();
    while ((q0.size() > 0 || q1.size() > 0 || req_valid != 2'b00 || exp_q.size() > 0) && cyc < max_cycles) begin
      @(posedge clk); #1;
      cyc++;
      if (o_req_ack != 2'b00) begin
        pred    = (req_valid == 2'b11) ? ~model_last : req_valid[1];
        exp_ack = (req_valid == 2'b00) ? 2'b00 : (pred ? 2'b10 : 2'b01);
        vectors++;
        if (o_req_ack !== exp_ack) begin
          miscompares++;
          $display("FAIL grant: ack=%b required %b (valid=%b)", o_req_ack, exp_ack, req_valid);
        end else begin
          cur = pred ? q1.pop_front() : q0.pop_front();
          model_last = pred;
          ack_log.push_back(pred);
          ack_cyc.push_back(cycle);
          req_valid[pred] = 1'b0;
          is_to = (slave_wait < 0);
          e_rd  = (is_to || cur[39]) ? '0 : exp_mem[cur[38:32]];
          if (cur[39] && !is_to && !slave_err) exp_mem[cur[38:32]] = cur[31:0];
          exp_q.push_back({pred, (is_to ? 1'b1 : slave_err), e_rd, (is_to ? 8'(TO) : 8'(slave_wait + 1))});
        end
      end
      if (o_PSEL) begin
        vectors++;
        if ({o_PWRITE, o_PADDR, o_PWDATA} !== cur) begin
          miscompares++;
          $display("FAIL apb_ctrl: write/addr/wdata=%b/%h/%h required %b/%h/%h",
                   o_PWRITE, o_PADDR, o_PWDATA, cur[39], cur[38:32], cur[31:0]);
        end
      end
      if (o_PSEL && o_PENABLE) acc_seen++;
      if (o_rsp_valid != 2'b00) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", o_rsp_valid);
        end else begin
          e   = exp_q.pop_front();
          got = {o_rsp_valid[1], o_rsp_err, o_rsp_rdata, 8'(acc_seen)};
          if (got !== e || o_rsp_valid !== (e[41] ? 2'b10 : 2'b01) || o_PSEL !== 1'b0 || o_PENABLE !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp: valid=%b err=%b rdata=%h access=%0d psel=%b required req%0d err=%b rdata=%h access=%0d psel=0",
                     o_rsp_valid, o_rsp_err, o_rsp_rdata, acc_seen, o_PSEL, e[41], e[40], e[39:8], e[7:0]);
          end
        end
        acc_seen = 0;
      end else begin
        vectors++;
        if (o_rsp_rdata !== '0 || o_rsp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_rsp: rdata=%h err=%b required 0/0 without rsp_valid", o_rsp_rdata, o_rsp_err);
        end
      end
      present();
    end
    if (q0.size() > 0 || q1.size() > 0 || req_valid != 2'b00 || exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL traffic_timeout: %0d requests, %0d responses outstanding after %0d cycles, required 0",
               q0.size() + q1.size(), exp_q.size(), max_cycles);
      q0.delete(); q1.delete(); exp_q.delete();
      req_valid = '0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({o_req_ack, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA, o_dbg_state} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b rsp=%b psel=%b penable=%b paddr=%h state=%0d required all 0",
               o_req_ack, o_rsp_valid, o_PSEL, o_PENABLE, o_PADDR, o_dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({o_req_ack, o_PSEL, o_dbg_state} !== '0) begin
      miscompares++;
      $display("FAIL idle_no_req: ack=%b psel=%b state=%0d required 0", o_req_ack, o_PSEL, o_dbg_state);
    end
  endtask

  task automatic test_read_after_write();
    slave_wait = 0; slave_err = 1'b0; rand_gap = 1'b0;
    q0.push_back({1'b1, 7'h05, 32'hDEADBEEF});
    run_traffic(100);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[AW-1:0] = 7'h05;
    req_wdata[DW-1:0] = $urandom;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    model_last = 1'b0;
    vectors++;
    if ({o_req_ack, o_PSEL, o_PENABLE, o_PWRITE, o_PADDR} !== {2'b01, 1'b1, 1'b0, 1'b0, 7'h05}) begin
      miscompares++;
      $display("FAIL raw_setup: ack=%b psel=%b penable=%b pwrite=%b paddr=%h required 01/1/0/0/05",
               o_req_ack, o_PSEL, o_PENABLE, o_PWRITE, o_PADDR);
    end
    @(posedge clk); #1;
    vectors++;
    if ({o_req_ack, o_PSEL, o_PENABLE, o_rsp_valid} !== {2'b00, 1'b1, 1'b1, 2'b00}) begin
      miscompares++;
      $display("FAIL raw_access: ack=%b psel=%b penable=%b rsp=%b required 00/1/1/00",
               o_req_ack, o_PSEL, o_PENABLE, o_rsp_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if ({o_rsp_valid, o_rsp_err, o_rsp_rdata, o_PSEL, o_PENABLE} !== {2'b01, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL raw_rsp: rsp=%b err=%b rdata=%h psel=%b required 01/0/deadbeef/0",
               o_rsp_valid, o_rsp_err, o_rsp_rdata, o_PSEL);
    end
    @(posedge clk); #1;
    vectors++;
    if ({o_rsp_valid, o_rsp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL raw_rsp_pulse: rsp=%b rdata=%h required 00/0", o_rsp_valid, o_rsp_rdata);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    slave_wait = 0; slave_err = 1'b0; rand_gap = 1'b0;
    ack_log.delete(); ack_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'($urandom), 7'($urandom_range(0, 15)), 32'($urandom)});
      q1.push_back({1'($urandom), 7'($urandom_range(0, 15)), 32'($urandom)});
    end
    run_traffic(200);
    vectors++;
    if (ack_log.size() != 6) begin
      miscompares++;
      $display("FAIL rr_count: %0d grants required 6", ack_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (ack_log[i] != 1'(i % 2) || (i > 0 && ack_cyc[i] - ack_cyc[i-1] != 3)) begin
          miscompares++;
          $display("FAIL rr_grant%0d: grant=%0d pitch=%0d required grant=%0d pitch=3",
                   i, ack_log[i], (i > 0) ? ack_cyc[i] - ack_cyc[i-1] : 3, i % 2);
        end
      end
    end
  endtask

  task automatic test_stall();
    slave_wait = 3; slave_err = 1'b0; rand_gap = 1'b0;
    q0.push_back({1'b1, 7'h11, 32'($urandom)});
    q1.push_back({1'b0, 7'h11, 32'($urandom)});
    run_traffic(100);
    vectors++;
    if (o_PSEL !== 1'b0 || o_dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL stall_idle: psel=%b state=%0d required 0/0", o_PSEL, o_dbg_state);
    end
  endtask

  task automatic test_timeout();
    slave_wait = -1; slave_err = 1'b0; rand_gap = 1'b0;
    q0.push_back({1'b0, 7'h05, 32'($urandom)});
    q1.push_back({1'b1, 7'h05, 32'($urandom)});
    run_traffic(200);
    slave_wait = 0;
    q1.push_back({1'b0, 7'h05, 32'($urandom)});
    run_traffic(50);
    vectors++;
    if (mem[5] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL timeout_no_write: mem[5]=%h required deadbeef", mem[5]);
    end
  endtask

  task automatic test_slverr();
    logic [AW-1:0] a;
    a = 7'($urandom_range(32, 63));
    slave_wait = 1; slave_err = 1'b1; rand_gap = 1'b0;
    q1.push_back({1'b1, a, 32'($urandom)});
    run_traffic(50);
    slave_err = 1'b0;
    q1.push_back({1'b0, a, 32'($urandom)});
    run_traffic(50);
    vectors++;
    if (mem[a] !== exp_mem[a]) begin
      miscompares++;
      $display("FAIL slverr_mem: mem[%h]=%h required %h", a, mem[a], exp_mem[a]);
    end
  endtask

  task automatic test_random();
    int n;
    rand_gap = 1'b1;
    for (int b = 0; b < 10; b++) begin
      slave_wait = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
      slave_err  = ($urandom_range(0, 3) == 0);
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) begin
        q0.push_back({1'($urandom), 7'($urandom_range(0, 15)), 32'($urandom)});
        q1.push_back({1'($urandom), 7'($urandom_range(0, 15)), 32'($urandom)});
      end
      run_traffic(2000);
    end
    rand_gap = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    seen = 1'b0;
    slave_wait = -1; slave_err = 1'b0;
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[2*AW-1:AW] = 7'h03;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o_req_ack[1]) req_valid[1] = 1'b0;
      if (o_PENABLE) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rst_reach_access: penable=%b required 1 within 10 cycles", o_PENABLE);
    end
    #2;
    rst = 1'b1;
    req_valid = '0;
    #1;
    vectors++;
    if ({o_req_ack, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA, o_dbg_state} !== '0) begin
      miscompares++;
      $display("FAIL rst_async: psel=%b penable=%b rsp=%b paddr=%h state=%0d required all 0",
               o_PSEL, o_PENABLE, o_rsp_valid, o_PADDR, o_dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({o_rsp_valid, o_PSEL} !== 3'b000) begin
        miscompares++;
        $display("FAIL rst_no_rsp: rsp=%b psel=%b required 00/0", o_rsp_valid, o_PSEL);
      end
    end
    model_last = 1'b1;
    acc_seen = 0;
    exp_q.delete();
    slave_wait = 0;
    ack_log.delete(); ack_cyc.delete();
    q0.push_back({1'b0, 7'h05, 32'($urandom)});
    q1.push_back({1'b0, 7'h03, 32'($urandom)});
    run_traffic(50);
    vectors++;
    if (ack_log.size() != 2 || ack_log[0] != 1'b0) begin
      miscompares++;
      $display("FAIL rst_first_grant: grants=%0d first=%0d required 2 grants, first 0",
               ack_log.size(), (ack_log.size() > 0) ? ack_log[0] : 1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    test_reset();
    test_read_after_write();
    test_round_robin();
    test_stall();
    test_timeout();
    test_slverr();
    test_random();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
